// File: rtl/bus_operand_stack_reg.sv
// Bus operand register with offset load, post-increment
// and a small save/restore LIFO for nested operand saves.
module bus_operand_stack_reg #(
  parameter int WIDTH       = 16,
  parameter int OFFSET_BITS = 9,
  parameter int SIGN_EXT    = 0,
  parameter int DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  inout  wire  [WIDTH-1:0]         DATA,
  output logic [WIDTH-1:0]         REG_OUT,
  input  logic                     ld,
  input  logic                     ofs_ld,
  input  logic                     out_en,
  input  logic                     inc,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     err_clr,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_q, r_d;
  logic [LW-1:0]    level_q, level_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] lifo_q [DEPTH];
  logic [WIDTH-1:0] lifo_d [DEPTH];

  logic [WIDTH-1:0] ext;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  logic             has_entry;
  logic             has_room;

  // Offset field of the bus, extended to full width.
  generate
    if (OFFSET_BITS >= WIDTH) begin : g_ext_full
      assign ext = DATA;
    end else if (SIGN_EXT != 0) begin : g_ext_sign
      assign ext = {{(WIDTH-OFFSET_BITS){DATA[OFFSET_BITS-1]}},
                    DATA[OFFSET_BITS-1:0]};
    end else begin : g_ext_zero
      assign ext = {{(WIDTH-OFFSET_BITS){1'b0}},
                    DATA[OFFSET_BITS-1:0]};
    end
  endgenerate

  assign has_entry = (level_q != '0);
  assign has_room  = (level_q != LW'(DEPTH));
  assign top_idx   = AW'(level_q - 1'b1);
  assign wr_idx    = AW'(level_q);

  // Next-state: register priority, LIFO moves and sticky error.
  always_comb begin
    r_d     = r_q;
    level_d = level_q;
    err_d   = err_q & ~err_clr;
    lifo_d  = lifo_q;
    if (push && pop) begin
      if (ld) begin
        r_d = DATA;
      end else if (ofs_ld) begin
        r_d = ext;
      end else if (has_entry) begin
        r_d             = lifo_q[top_idx];
        lifo_d[top_idx] = r_q;
      end else begin
        lifo_d[wr_idx] = r_q;
        level_d        = level_q + 1'b1;
        err_d          = 1'b1;
      end
    end else begin
      if (ld) begin
        r_d = DATA;
      end else if (ofs_ld) begin
        r_d = ext;
      end else if (pop) begin
        if (has_entry) begin
          r_d = lifo_q[top_idx];
        end
      end else if (inc) begin
        r_d = r_q + 1'b1;
      end
      if (pop) begin
        if (has_entry) begin
          level_d = level_q - 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      if (push) begin
        if (has_room) begin
          lifo_d[wr_idx] = r_q;
          level_d        = level_q + 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q     <= '0;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      r_q     <= r_d;
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  // LIFO storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    lifo_q <= lifo_d;
  end

  assign DATA    = out_en ? r_q : 'z;
  assign REG_OUT = ld ? DATA : (ofs_ld ? ext : r_q);
  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bus_operand_stack_reg.sv
// Bench for bus_operand_stack_reg: directed cases then
// random strobes against a queue-based reference model.
module tb_bus_operand_stack_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  wire  [15:0] bus;
  logic [15:0] drv;
  logic        drv_en;
  assign bus = drv_en ? drv : 16'hzzzz;

  logic ld, ofs_ld, out_en, inc, push, pop, err_clr;
  logic [15:0] reg_out, reg_out1;
  logic full, empty, err, full1, empty1, err1;
  logic [2:0] level, level1;

  bus_operand_stack_reg #(
    .WIDTH(16), .OFFSET_BITS(9), .SIGN_EXT(0), .DEPTH(4)
  ) u0 (
    .clk(clk), .reset(reset), .DATA(bus), .REG_OUT(reg_out),
    .ld(ld), .ofs_ld(ofs_ld), .out_en(out_en), .inc(inc),
    .push(push), .pop(pop), .err_clr(err_clr),
    .full(full), .empty(empty), .level(level), .err(err)
  );

  bus_operand_stack_reg #(
    .WIDTH(16), .OFFSET_BITS(9), .SIGN_EXT(1), .DEPTH(4)
  ) u1 (
    .clk(clk), .reset(reset), .DATA(bus), .REG_OUT(reg_out1),
    .ld(1'b0), .ofs_ld(ofs_ld), .out_en(1'b0), .inc(1'b0),
    .push(1'b0), .pop(1'b0), .err_clr(1'b0),
    .full(full1), .empty(empty1), .level(level1), .err(err1)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] m_r, m1_r;
  logic        m_err;
  logic [15:0] stk[$];

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] zx(logic [15:0] d);
    return {7'b0, d[8:0]};
  endfunction

  function automatic logic [15:0] sx(logic [15:0] d);
    return {{7{d[8]}}, d[8:0]};
  endfunction

  task automatic idle();
    ld = 0; ofs_ld = 0; out_en = 0; inc = 0;
    push = 0; pop = 0; err_clr = 0; drv_en = 0;
  endtask

  task automatic state_check();
    check("r", reg_out, m_r);
    check("level", level, stk.size());
    check("full", full, stk.size() == 4);
    check("empty", empty, stk.size() == 0);
    check("err", err, m_err);
    check("r_sx", reg_out1, m1_r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    stk.delete();
    m_r = 0; m1_r = 0; m_err = 0;
    #1;
    check("rst_r", reg_out, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_err", err, 0);
    check("rst_lvl", level, 0);
    state_check();
  endtask

  task automatic step(bit l, bit o, bit i, bit pu, bit po,
                      bit c, bit oe, logic [15:0] d);
    logic [15:0] b, old, nr;
    logic        ne;
    @(negedge clk);
    ld = l; ofs_ld = o; inc = i; push = pu; pop = po;
    err_clr = c; out_en = oe; drv = d; drv_en = !oe;
    b = oe ? m_r : d;
    #1;
    check("lookahead", reg_out, l ? b : (o ? zx(b) : m_r));
    if (oe) check("bus_drive", bus, m_r);
    if (o) check("la_sx", reg_out1, sx(b));
    @(posedge clk);
    old = m_r;
    nr  = m_r;
    ne  = m_err & !c;
    if (l) nr = b;
    else if (o) nr = zx(b);
    if (pu && po) begin
      if (!(l || o)) begin
        if (stk.size() > 0) begin
          nr = stk[stk.size()-1];
          stk[stk.size()-1] = old;
        end else begin
          stk.push_back(old);
          ne = 1;
        end
      end
    end else begin
      if (po) begin
        if (stk.size() > 0) begin
          if (!(l || o)) nr = stk.pop_back();
          else void'(stk.pop_back());
        end else ne = 1;
      end else if (i && !(l || o)) begin
        nr = old + 16'd1;
      end
      if (pu) begin
        if (stk.size() < 4) stk.push_back(old);
        else ne = 1;
      end
    end
    m_r = nr;
    m_err = ne;
    if (o) m1_r = sx(b);
    #1 idle();
    #1 state_check();
  endtask

  initial begin
    idle();
    drv = 0;
    reset = 1;
    m_r = 0; m1_r = 0; m_err = 0;
    repeat (2) @(posedge clk);
    do_reset();

    step(1,0,0,0,0,0,0,16'h1234);
    check("ld1234", reg_out, 16'h1234);
    step(0,0,0,0,0,0,1,16'h0000);
    step(1,0,0,0,0,0,1,16'h0000);
    check("oe_ld_self", reg_out, 16'h1234);

    step(0,1,0,0,0,0,0,16'hFF55);
    check("ofs_zx", reg_out, 16'h0155);
    check("ofs_sx", reg_out1, 16'hFF55);
    step(0,1,0,0,0,0,0,16'h00AA);
    check("ofs_zx_aa", reg_out, 16'h00AA);
    check("ofs_sx_aa", reg_out1, 16'h00AA);

    for (int k = 1; k <= 4; k++) begin
      step(1,0,0,0,0,0,0,16'(k));
      step(0,0,0,1,0,0,0,16'h0);
    end
    check("lvl4", level, 4);
    check("full4", full, 1);
    step(0,0,0,1,0,0,0,16'h0);
    check("ovf_err", err, 1);
    check("ovf_lvl", level, 4);
    for (int k = 4; k >= 1; k--) begin
      step(0,0,0,0,1,0,0,16'h0);
      check("pop_val", reg_out, 16'(k));
    end
    check("empty0", empty, 1);
    step(0,0,0,0,1,0,0,16'h0);
    check("unf_r", reg_out, 16'h0001);
    check("unf_err", err, 1);
    step(0,0,0,0,0,1,0,16'h0);
    check("clr_err", err, 0);

    step(1,0,0,0,0,0,0,16'hFFFF);
    step(0,0,1,0,0,0,0,16'h0);
    check("inc_wrap", reg_out, 16'h0000);
    step(1,0,0,0,0,0,0,16'h0005);
    step(0,0,0,1,0,0,0,16'h0);
    step(1,0,0,0,0,0,0,16'h0010);
    step(0,0,0,1,1,0,0,16'h0);
    check("swap_r", reg_out, 16'h0005);
    check("swap_lvl", level, 1);
    step(0,0,0,0,1,0,0,16'h0);
    check("swap_top", reg_out, 16'h0010);

    step(1,0,0,0,0,0,0,16'h0007);
    step(1,0,0,1,0,0,0,16'h00AB);
    check("ldpush_r", reg_out, 16'h00AB);
    step(0,0,0,0,1,0,0,16'h0);
    check("ldpush_top", reg_out, 16'h0007);
    step(0,0,0,0,1,1,0,16'h0);
    check("clr_vs_set", err, 1);

    step(0,0,0,1,0,1,0,16'h0);
    step(0,0,0,1,0,0,0,16'h0);
    step(0,0,0,1,0,0,0,16'h0);
    do_reset();
    step(0,0,0,0,1,0,0,16'h0);
    check("pop_after_rst", err, 1);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset();
      end else begin
        step($urandom_range(0, 5) == 0,
             $urandom_range(0, 6) == 0,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 2) == 0,
             $urandom_range(0, 2) == 0,
             $urandom_range(0, 7) == 0,
             $urandom_range(0, 4) == 0,
             16'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
